// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Fetch looks it up combinationally to choose the next PC. The resolve stage
// updates it, and receives a mispredict flag and the corrected PC in return.
// Running statistics count resolved branches and mispredicts.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             enable,
   input  logic             flush_all,
   input  logic [31:0]      pc_IF,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_is_jump,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_pred_taken,
   input  logic [31:0]      upd_pred_target,
   output logic             mispredict,
   output logic [31:0]      correct_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   // Counter encodings. MAX is all ones, INIT is 01..1 (weakly not-taken)
   // and WT is 10..0 (weakly taken). These also hold when CTR_W is 1.
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
   localparam logic [CTR_W-1:0] CTR_WT   = ~CTR_INIT;
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [ENTRIES-1:0]             valid_q,  valid_d;
   logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
   logic [ENTRIES-1:0][31:0]       target_q, target_d;
   logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q,    ctr_d;
   logic [CNT_W-1:0]               branch_cnt_q,  branch_cnt_d;
   logic [CNT_W-1:0]               mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] lk_idx_s;
   logic [TAG_W-1:0] lk_tag_s;
   logic             lk_hit_s;
   logic [IDX_W-1:0] upd_idx_s;
   logic [TAG_W-1:0] upd_tag_s;
   logic             upd_hit_s;
   logic             eff_taken_s;
   logic             upd_en_s;

   assign lk_idx_s    = pc_IF[IDX_W+1:2];
   assign lk_tag_s    = pc_IF[31:IDX_W+2];
   assign upd_idx_s   = upd_pc[IDX_W+1:2];
   assign upd_tag_s   = upd_pc[31:IDX_W+2];
   assign eff_taken_s = upd_taken | upd_is_jump;
   assign upd_en_s    = upd_valid & enable;

   // Fetch lookup: hit and direction from the current (pre-update) contents.
   always_comb begin
      lk_hit_s    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
      pred_taken  = lk_hit_s && ctr_q[lk_idx_s][CTR_W-1];
      if (pred_taken) begin
         pred_target = target_q[lk_idx_s];
      end else begin
         pred_target = pc_IF + 32'd4;
      end
   end

   // Resolve-side check: compare the carried prediction with the actual outcome.
   always_comb begin
      upd_hit_s  = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      mispredict = upd_valid &&
                   ((upd_pred_taken != eff_taken_s) ||
                    (eff_taken_s && (upd_pred_target != upd_target)));
      if (eff_taken_s) begin
         correct_pc = upd_target;
      end else begin
         correct_pc = upd_pc + 32'd4;
      end
   end

   // BTB next state: a flush wins over an update, and not-taken misses never allocate.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (flush_all) begin
         valid_d = '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_d[i] = CTR_INIT;
         end
      end else if (upd_en_s) begin
         if (upd_hit_s) begin
            if (eff_taken_s) begin
               target_d[upd_idx_s] = upd_target;
               if (upd_is_jump || (ctr_q[upd_idx_s] == CTR_MAX)) begin
                  ctr_d[upd_idx_s] = CTR_MAX;
               end else begin
                  ctr_d[upd_idx_s] = ctr_q[upd_idx_s] + CTR_ONE;
               end
            end else begin
               if (ctr_q[upd_idx_s] == '0) begin
                  ctr_d[upd_idx_s] = '0;
               end else begin
                  ctr_d[upd_idx_s] = ctr_q[upd_idx_s] - CTR_ONE;
               end
            end
         end else if (eff_taken_s) begin
            valid_d[upd_idx_s]  = 1'b1;
            tag_d[upd_idx_s]    = upd_tag_s;
            target_d[upd_idx_s] = upd_target;
            if (upd_is_jump) begin
               ctr_d[upd_idx_s] = CTR_MAX;
            end else begin
               ctr_d[upd_idx_s] = CTR_WT;
            end
         end else begin
            valid_d = valid_q;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Statistics next state: gated only by enable. A flush does not touch the counts.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (upd_en_s) begin
         branch_cnt_d = branch_cnt_q + CNT_ONE;
         if (mispredict) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
         end else begin
            mispred_cnt_d = mispred_cnt_q;
         end
      end else begin
         branch_cnt_d = branch_cnt_q;
      end
   end

   // State registers: an asynchronous reset clears every entry and both counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q       <= '0;
         tag_q         <= '0;
         target_q      <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         ctr_q         <= ctr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor (ENTRIES=16, CTR_W=2).
// Each table row is one cycle. The lookup and resolve outputs are checked
// before the edge, and the counts expected at that point come from the rows
// before it. Hand-written sequences follow for asynchronous reset and stats.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        enable, flush_all;
   logic [31:0] pc_IF;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        mispredict;
   logic [31:0] correct_pc;
   logic [31:0] branch_cnt, mispredict_cnt;

   int errors = 0;
   int checks = 0;

   branch_predictor #(.ENTRIES(16), .CTR_W(2), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .enable(enable), .flush_all(flush_all),
      .pc_IF(pc_IF), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .correct_pc(correct_pc),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic        flush, en, uv;
      logic [31:0] upc;
      logic        jmp, tk;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mp;
      logic [31:0] e_cpc, e_bc, e_mc;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic [31:0] pc, input logic flush, input logic en,
                               input logic uv, input logic [31:0] upc, input logic jmp,
                               input logic tk, input logic [31:0] tgt, input logic ptk,
                               input logic [31:0] ptgt, input logic e_pt,
                               input logic [31:0] e_ptgt, input logic e_mp,
                               input logic [31:0] e_cpc, input logic [31:0] e_bc,
                               input logic [31:0] e_mc);
      vec_t v;
      v.pc = pc; v.flush = flush; v.en = en; v.uv = uv; v.upc = upc; v.jmp = jmp;
      v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt; v.e_pt = e_pt;
      v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_cpc = e_cpc; v.e_bc = e_bc; v.e_mc = e_mc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_upd(input logic uv, input logic [31:0] upc, input logic jmp,
                            input logic tk, input logic [31:0] tgt, input logic ptk,
                            input logic [31:0] ptgt);
      upd_valid = uv; upd_pc = upc; upd_is_jump = jmp; upd_taken = tk;
      upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
   endtask

   initial begin
      //         pc     fl en uv upc    j  t  tgt     ptk ptgt    e_pt e_ptgt  mp cpc     bc  mc
      vecs[0]  = mk(32'h40, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   0,  0);
      vecs[1]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 0,  0);
      vecs[2]  = mk(32'h40, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h4,   1,  1);
      vecs[3]  = mk(32'h80, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 32'h4,   1,  1);
      vecs[4]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  1,  1);
      vecs[5]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h44,  2,  2);
      vecs[6]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 3,  2);
      vecs[7]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 4,  3);
      vecs[8]  = mk(32'h40, 0, 1, 1, 32'h40, 1, 0, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, 5,  4);
      vecs[9]  = mk(32'h40, 0, 1, 1, 32'h40, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  6,  4);
      vecs[10] = mk(32'h40, 0, 1, 1, 32'h40, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  7,  5);
      vecs[11] = mk(32'h40, 0, 1, 1, 32'h80, 0, 1, 32'h180, 0, 32'h84,  0, 32'h44,  1, 32'h180, 8,  6);
      vecs[12] = mk(32'h40, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   9,  7);
      vecs[13] = mk(32'h80, 0, 1, 1, 32'h20, 0, 1, 32'h200, 1, 32'h300, 1, 32'h180, 1, 32'h200, 9,  7);
      vecs[14] = mk(32'h20, 0, 0, 1, 32'h20, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h24,  10, 8);
      vecs[15] = mk(32'h20, 1, 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44,  1, 32'h200, 1, 32'h100, 10, 8);
      vecs[16] = mk(32'h40, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   11, 9);
      vecs[17] = mk(32'h80, 0, 1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 32'h4,   11, 9);
      vecs[18] = mk(32'h20, 0, 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44,  0, 32'h24,  1, 32'h100, 11, 9);

      nRST = 1'b0; enable = 1'b0; flush_all = 1'b0; pc_IF = 32'h0;
      drive_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      #12 nRST = 1'b1;

      for (int i = 0; i < 19; i++) begin
         pc_IF = vecs[i].pc; flush_all = vecs[i].flush; enable = vecs[i].en;
         drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].jmp, vecs[i].tk, vecs[i].tgt,
                   vecs[i].ptk, vecs[i].ptgt);
         #1;
         chk($sformatf("row%0d pred_taken", i),     {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
         chk($sformatf("row%0d pred_target", i),    pred_target,         vecs[i].e_ptgt);
         chk($sformatf("row%0d mispredict", i),     {31'b0, mispredict}, {31'b0, vecs[i].e_mp});
         chk($sformatf("row%0d correct_pc", i),     correct_pc,          vecs[i].e_cpc);
         chk($sformatf("row%0d branch_cnt", i),     branch_cnt,          vecs[i].e_bc);
         chk($sformatf("row%0d mispredict_cnt", i), mispredict_cnt,      vecs[i].e_mc);
         @(posedge CLK); #1;
      end

      // Asynchronous reset mid-cycle while an evicting update is pending.
      flush_all = 1'b0; enable = 1'b1; pc_IF = 32'h40;
      drive_upd(1, 32'h80, 0, 1, 32'h180, 0, 32'h84);
      #1;
      chk("rst pre pred_taken", {31'b0, pred_taken}, 32'd1);
      chk("rst pre branch_cnt", branch_cnt, 32'd12);
      #1 nRST = 1'b0;
      #1;
      chk("rst pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("rst pred_target", pred_target, 32'h44);
      chk("rst branch_cnt", branch_cnt, 32'd0);
      chk("rst mispredict_cnt", mispredict_cnt, 32'd0);
      chk("rst mispredict", {31'b0, mispredict}, 32'd1);
      chk("rst correct_pc", correct_pc, 32'h180);
      @(posedge CLK); #1;
      pc_IF = 32'h80; #1;
      chk("rst held 0x80 pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("rst held 0x80 pred_target", pred_target, 32'h84);
      chk("rst held branch_cnt", branch_cnt, 32'd0);
      drive_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      @(negedge CLK); nRST = 1'b1;
      @(posedge CLK); #1;
      chk("post rst 0x80 pred_taken", {31'b0, pred_taken}, 32'd0);
      pc_IF = 32'h40; #1;
      chk("post rst 0x40 pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("post rst 0x40 pred_target", pred_target, 32'h44);

      // A single mispredicted branch bumps both counters by one.
      drive_upd(1, 32'h20, 0, 1, 32'h200, 0, 32'h24);
      #1;
      chk("stats mispredict", {31'b0, mispredict}, 32'd1);
      chk("stats correct_pc", correct_pc, 32'h200);
      @(posedge CLK); #1;
      drive_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      #1;
      chk("stats branch_cnt", branch_cnt, 32'd1);
      chk("stats mispredict_cnt", mispredict_cnt, 32'd1);
      pc_IF = 32'h20; #1;
      chk("stats 0x20 pred_target", pred_target, 32'h200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined MIPS core. Fetch looks it up combinationally to pick the next PC. The stage that resolves branches and jumps updates it and receives a mispredict flag plus the corrected PC. It replaces the fixed "PC+4 until resolved" fetch policy and keeps running prediction statistics.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_W, 2: direction counter width, ≥1; predict taken when counter MSB = 1
- CNT_W, 32: width of statistics counters

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- enable  in  1  pipeline advance (ihit || dhit); gates all updates and statistics
- flush_all  in  1  invalidate every entry; not gated by enable
- pc_IF  in  32  fetch address for lookup
- pred_taken  out  1  predicted taken for pc_IF
- pred_target  out  32  predicted next PC for pc_IF
- upd_valid  in  1  a branch or jump resolves this cycle
- upd_pc  in  32  address of the resolved instruction
- upd_is_jump  in  1  unconditional (j/jal/jr); always taken
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction
- upd_pred_target  in  32  predicted target carried down the pipe
- mispredict  out  1  resolved outcome differs from prediction
- correct_pc  out  32  PC that fetch must redirect to on mispredict
- branch_cnt  out  CNT_W  resolved branches/jumps
- mispredict_cnt  out  CNT_W  mispredicts

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[CTR_W-1:0]. Index = pc[IDX_W+1:2]. pc[1:0] is ignored.
- Counter init value CTR_INIT = 2^(CTR_W-1)-1 (weakly not-taken). Weakly taken = 2^(CTR_W-1). Max = 2^CTR_W-1.
- Lookup is combinational. hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx] MSB.
  - pred_target = pred_taken ? target[idx] : pc_IF+4 (mod 2^32).
- Update is applied on the clock edge when upd_valid && enable && !flush_all. Let eff_taken = upd_taken || upd_is_jump.
  - Hit, eff_taken: ctr saturating +1 (jump: ctr = max); target <= upd_target.
  - Hit, not taken: ctr saturating -1; target is unchanged.
  - Miss, eff_taken: allocate/overwrite the entry. valid = 1, tag and target are written, and ctr = weakly taken (jump: max).
  - Miss, not taken: no change. Not-taken branches are never allocated.
- Mispredict is combinational:
  - mispredict = upd_valid && (upd_pred_taken != eff_taken || (eff_taken && upd_pred_target != upd_target)).
  - correct_pc = eff_taken ? upd_target : upd_pc+4.
  - Both are valid regardless of enable.
- flush_all on an edge: all valid = 0 and all ctr = CTR_INIT. It has priority over a simultaneous update. Statistics are untouched.
- Statistics:
  - branch_cnt +1 on each edge with upd_valid && enable.
  - mispredict_cnt +1 when mispredict is also high.
  - Both wrap modulo 2^CNT_W. Only nRST clears them.

## Timing
- Lookup latency 0 cycles; update visible to lookup on the cycle after the edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. There is no bypass.
- Reset (asynchronous, any time, including mid-update): all valid = 0, ctr = CTR_INIT, stats = 0. While reset is held, pred_taken = 0, pred_target = pc_IF+4, and mispredict follows its inputs.
- enable = 0: no state changes except flush_all. Outputs stay combinational.
- Aliasing: a new taken update to the same index with a different tag evicts the old entry.

## Test plan
Parameters for all scenarios: ENTRIES=16, CTR_W=2.
- After reset, pc_IF=0x40 -> pred_taken=0, pred_target=0x44, branch_cnt=0.
- Update upd_pc=0x40, taken, target 0x100, enable=1. Next cycle pc_IF=0x40 -> pred_taken=1, pred_target=0x100 (ctr=2).
- With 0x40 allocated, pc_IF=0x80 (same index 0, different tag) -> pred_taken=0, pred_target=0x84. A taken update at 0x80 then evicts 0x40, and lookup of 0x40 -> not taken, 0x44.
- From ctr=2 at 0x40, two not-taken updates -> after the first, pred_taken=0 (ctr=1); after the second, ctr=0. Two further taken updates -> ctr 1 then 2, pred_taken=1. A jump update sets ctr=3 immediately.
- upd_valid=1, upd_pc=0x20, upd_pred_taken=0, upd_taken=1, upd_target=0x200 -> mispredict=1, correct_pc=0x200. Next edge: branch_cnt=1, mispredict_cnt=1. Predicted taken to 0x300 but actual target 0x200 -> mispredict=1.
- Two cases leave the BTB unchanged:
  - upd_valid=1 with enable=0 -> no BTB or stats change.
  - flush_all=1 together with a taken update to 0x40 -> every lookup misses next cycle, while the stats still reflect prior counts.
- Assert nRST=0 asynchronously mid-cycle during an update -> all state is cleared immediately and nothing is written.
